// File: rtl/seg_display_arbiter_pkg.sv
// Shared definitions for the seven-segment display arbiter.
// Contents:
//   SEG_0..SEG_9, SEG_DASH, SEG_BLANK : segment patterns {g,f,e,d,c,b,a}, active-high
//   state_t                           : arbiter state encoding (IDLE, SHOW)
package seg_display_arbiter_pkg;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic ST_IDLE_ENC = 1'b0;
    localparam logic ST_SHOW_ENC = 1'b1;

    typedef enum logic {
        ST_IDLE = ST_IDLE_ENC,
        ST_SHOW = ST_SHOW_ENC
    } state_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to seven-segment decoder.
// Ports:
//   digit : in  4-bit BCD nibble; values above 9 render as a dash
//   seg   : out segment pattern {g,f,e,d,c,b,a}, active-high
module bcd_to_7seg
    import seg_display_arbiter_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Time-sliced round-robin arbiter sharing a two-digit seven-segment display
// among NREQ requesters. Requester 0 is urgent: it preempts any other owner
// and keeps the display for as long as it requests.
// Ports:
//   clk   : in  system clock, rising edge
//   reset : in  synchronous active-high reset
//   req   : in  NREQ level-sensitive requests
//   bcd   : in  8*NREQ packed BCD values, source i at [8i+7:8i] (tens in [7:4])
//   grant : out one-hot display owner, zero when idle (registered)
//   busy  : out high whenever grant is non-zero (registered)
//   ten   : out tens digit segments (registered)
//   one   : out ones digit segments (registered)
module seg_display_arbiter
    import seg_display_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DWELL = 50_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   bcd,
    output logic [NREQ-1:0]     grant,
    output logic                busy,
    output logic [6:0]          ten,
    output logic [6:0]          one
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state_reg, state_next;
    logic [NREQ-1:0] grant_reg, grant_next;
    logic [PW-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [CW-1:0]   dwell_reg, dwell_next;
    logic            busy_reg;
    logic [6:0]      ten_reg, one_reg;

    logic [PW-1:0]   pick;
    logic            take;
    logic [7:0]      show_byte;
    logic [6:0]      seg_ten, seg_one;

    // Winner selection: requester 0 always wins when present; otherwise the
    // first set bit after ptr, wrapping. ptr itself is scanned last, so a lone
    // current owner is re-picked when its slice expires.
    function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [PW-1:0]   ptr);
        logic [PW-1:0] win;
        win = '0;
        if (!r[0]) begin
            // Descending scan so the nearest candidate is written last.
            for (int k = NREQ; k >= 1; k--) begin
                int idx;
                idx = (int'(ptr) + k) % NREQ;
                if (r[idx]) win = PW'(idx);
            end
        end
        return win;
    endfunction

    // While showing, rr_ptr_reg always names the current owner because it is
    // rewritten on every grant change.
    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        rr_ptr_next = rr_ptr_reg;
        dwell_next  = dwell_reg;
        take        = 1'b0;
        pick        = rr_pick(req, rr_ptr_reg);

        case (state_reg)
            ST_IDLE: begin
                if (|req) take = 1'b1;
            end
            ST_SHOW: begin
                if (req[0] && !grant_reg[0]) begin
                    take = 1'b1;
                end else if (!req[rr_ptr_reg]) begin
                    if (|req) begin
                        take = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                        grant_next = '0;
                    end
                end else if (dwell_reg == '0) begin
                    take = 1'b1;
                end else begin
                    dwell_next = dwell_reg - CW'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                grant_next = '0;
            end
        endcase

        if (take) begin
            state_next  = ST_SHOW;
            grant_next  = NREQ'(1) << pick;
            rr_ptr_next = pick;
            dwell_next  = CW'(DWELL - 1);
        end
    end

    // Segments are decoded from the owner being granted on this edge, so the
    // display changes together with grant.
    assign show_byte = bcd[int'(rr_ptr_next)*8 +: 8];

    bcd_to_7seg u_ten (.digit(show_byte[7:4]), .seg(seg_ten));
    bcd_to_7seg u_one (.digit(show_byte[3:0]), .seg(seg_one));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            grant_reg  <= '0;
            rr_ptr_reg <= PW'(NREQ - 1);
            dwell_reg  <= '0;
            busy_reg   <= 1'b0;
            ten_reg    <= SEG_BLANK;
            one_reg    <= SEG_BLANK;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            rr_ptr_reg <= rr_ptr_next;
            dwell_reg  <= dwell_next;
            busy_reg   <= |grant_next;
            ten_reg    <= (|grant_next) ? seg_ten : SEG_BLANK;
            one_reg    <= (|grant_next) ? seg_one : SEG_BLANK;
        end
    end

    assign grant = grant_reg;
    assign busy  = busy_reg;
    assign ten   = ten_reg;
    assign one   = one_reg;

endmodule

// File: tb/tb_seg_display_arbiter.sv
module tb_seg_display_arbiter;

    localparam int NREQ  = 4;
    localparam int DWELL = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] bcd;
    logic [3:0]  grant;
    logic        busy;
    logic [6:0]  ten;
    logic [6:0]  one;

    always #5 clk = ~clk;

    seg_display_arbiter #(.NREQ(NREQ), .DWELL(DWELL)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .bcd   (bcd),
        .grant (grant),
        .busy  (busy),
        .ten   (ten),
        .one   (one)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: owner index (-1 = idle), last owner for rotation,
    // and how many cycles the current owner has been on screen.
    int m_owner = -1;
    int m_last  = NREQ - 1;
    int m_held  = 0;

    logic [3:0] exp_grant;
    logic       exp_busy;
    logic [6:0] exp_ten;
    logic [6:0] exp_one;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'b0111111;
            4'd1: return 7'b0000110;
            4'd2: return 7'b1011011;
            4'd3: return 7'b1001111;
            4'd4: return 7'b1100110;
            4'd5: return 7'b1101101;
            4'd6: return 7'b1111101;
            4'd7: return 7'b0000111;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1101111;
            default: return 7'b1000000;
        endcase
    endfunction

    function automatic int choose(input logic [3:0] r, input int last);
        if (r[0]) return 0;
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    // Advance the model with the inputs present at the coming edge, then clock.
    task automatic tick();
        int  nxt;
        bit  take;
        logic [7:0] b;
        take = 1'b0;
        nxt  = m_owner;
        if (reset) begin
            m_owner = -1;
            m_last  = NREQ - 1;
            m_held  = 0;
        end else begin
            if (m_owner < 0) begin
                if (req != 0) begin take = 1'b1; nxt = choose(req, m_last); end
            end else if (req[0] && m_owner != 0) begin
                take = 1'b1; nxt = 0;
            end else if (!req[m_owner]) begin
                take = 1'b1; nxt = (req != 0) ? choose(req, m_last) : -1;
            end else if (m_held == DWELL) begin
                take = 1'b1; nxt = choose(req, m_last);
            end else begin
                m_held++;
            end
            if (take) begin
                m_owner = nxt;
                m_held  = 1;
                if (nxt >= 0) m_last = nxt;
            end
        end
        if (m_owner < 0) begin
            exp_grant = 4'b0000; exp_busy = 1'b0; exp_ten = 7'b0; exp_one = 7'b0;
        end else begin
            b = bcd[m_owner*8 +: 8];
            exp_grant = 4'b0001 << m_owner;
            exp_busy  = 1'b1;
            exp_ten   = seg_of(b[7:4]);
            exp_one   = seg_of(b[3:0]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 4'($urandom);
        bcd   = $urandom;
        tick();
        checks++;
        if ({grant, busy, ten, one} !== 19'b0) begin
            errors++;
            $display("FAIL reset: grant=%b busy=%b ten=%b one=%b expected all zero", grant, busy, ten, one);
        end
        reset = 1'b0;
        req   = 4'b0000;
        tick();
        checks++;
        if ({grant, busy} !== 5'b0) begin
            errors++;
            $display("FAIL idle_after_reset: grant=%b busy=%b expected 0000 0", grant, busy);
        end
        $display("reset: grant=%b busy=%b ten=%b one=%b", grant, busy, ten, one);
    endtask

    task automatic test_hold();
        req = 4'b0010;
        bcd = 32'h0000_4200;
        tick();
        checks++;
        if ({grant, busy, ten, one} !== {4'b0010, 1'b1, 7'b1100110, 7'b1011011}) begin
            errors++;
            $display("FAIL first_grant: grant=%b busy=%b ten=%b one=%b expected 0010 1 1100110 1011011",
                     grant, busy, ten, one);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (grant !== 4'b0010 || {grant, busy, ten, one} !== {exp_grant, exp_busy, exp_ten, exp_one}) begin
                errors++;
                $display("FAIL hold: cycle %0d grant=%b ten=%b one=%b expected 0010 %b %b", i, grant, ten, one, exp_ten, exp_one);
            end
        end
        $display("hold: grant=%b ten=%b one=%b", grant, ten, one);
    endtask

    task automatic test_rotate();
        int changes;
        logic [3:0] prev;
        req = 4'b0110;
        bcd = 32'h0037_4200;
        changes = 0;
        prev = grant;
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++;
            if ({grant, busy, ten, one} !== {exp_grant, exp_busy, exp_ten, exp_one}) begin
                errors++;
                $display("FAIL rotate: cycle %0d grant=%b ten=%b one=%b expected %b %b %b",
                         i, grant, ten, one, exp_grant, exp_ten, exp_one);
            end
            if (grant !== prev) changes++;
            prev = grant;
        end
        checks++;
        if (changes != 4) begin
            errors++;
            $display("FAIL rotate_count: grant changes=%0d expected 4", changes);
        end
        $display("rotate: grant changes=%0d over 16 cycles", changes);
    endtask

    task automatic test_preempt();
        reset = 1'b1; tick(); reset = 1'b0;
        req = 4'b0100;
        bcd = 32'h0091_0013;
        tick(); tick();
        req = 4'b0101;
        tick();
        checks++;
        if ({grant, ten, one} !== {4'b0001, 7'b0000110, 7'b1001111}) begin
            errors++;
            $display("FAIL preempt: grant=%b ten=%b one=%b expected 0001 0000110 1001111", grant, ten, one);
        end
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++;
            if (grant !== 4'b0001 || grant !== exp_grant) begin
                errors++;
                $display("FAIL urgent_hold: cycle %0d grant=%b expected 0001", i, grant);
            end
        end
        req = 4'b0100;
        tick();
        checks++;
        if ({grant, ten, one} !== {4'b0100, 7'b1101111, 7'b0000110}) begin
            errors++;
            $display("FAIL preempt_return: grant=%b ten=%b one=%b expected 0100 1101111 0000110", grant, ten, one);
        end
        $display("preempt: returned grant=%b", grant);
    endtask

    task automatic test_dash();
        req = 4'b0010;
        bcd = 32'h0000_A500;
        tick(); tick();
        checks++;
        if ({grant, ten, one} !== {4'b0010, 7'b1000000, 7'b1101101}) begin
            errors++;
            $display("FAIL dash: grant=%b ten=%b one=%b expected 0010 1000000 1101101", grant, ten, one);
        end
        $display("dash: ten=%b one=%b", ten, one);
    endtask

    task automatic test_reset_mid();
        req = 4'b1111;
        bcd = $urandom;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({grant, busy, ten, one} !== 19'b0) begin
            errors++;
            $display("FAIL reset_mid: grant=%b busy=%b ten=%b one=%b expected all zero", grant, busy, ten, one);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (grant !== 4'b0001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: grant=%b busy=%b expected 0001 1", grant, busy);
        end
        $display("reset_mid: grant after release=%b", grant);
    endtask

    task automatic test_random();
        int bad;
        logic [3:0] req_at_edge;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            if ($urandom_range(0, 5) == 0) req[0] = 1'b0;
            bcd   = $urandom;
            reset = ($urandom_range(0, 99) == 0);
            req_at_edge = req;
            tick();
            checks++;
            if ({grant, busy, ten, one} !== {exp_grant, exp_busy, exp_ten, exp_one}) begin
                errors++; bad++;
                $display("FAIL random: cycle %0d req=%b grant=%b busy=%b ten=%b one=%b expected %b %b %b %b",
                         i, req_at_edge, grant, busy, ten, one, exp_grant, exp_busy, exp_ten, exp_one);
            end
            checks++;
            if (!$onehot0(grant) || busy !== (|grant) || (grant & ~req_at_edge) !== 4'b0) begin
                errors++; bad++;
                $display("FAIL invariant: cycle %0d req=%b grant=%b busy=%b", i, req_at_edge, grant, busy);
            end
        end
        reset = 1'b0;
        $display("random: 400 cycles, %0d discrepancies", bad);
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        bcd   = 32'h0;
        test_reset();
        test_hold();
        test_rotate();
        test_preempt();
        test_dash();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
